// File: rtl/tx_frame_unpacker_if.sv
// Input-word stream bundle for tx_frame_unpacker.
//   tdata  : one signed I or Q word
//   tvalid : word present
//   tlast  : last word of a frame
//   tready : sink can accept a word this cycle
// master drives data/valid/last; slave drives ready.
interface tx_frame_unpacker_if #(
    parameter int SAMP_WIDTH = 16
);
    logic [SAMP_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tx_frame_unpacker.sv
// Transmit-side frame unpacker.
// Collects 2*NUM_CHANS interleaved I/Q words (word 2k = real, 2k+1 = imag of
// channel k) into a pending buffer, checks framing against tlast, and once
// every INTERP clocks presents the whole frame in parallel, left-shifted by
// gain_shift with saturation. A tick with no pending frame emits zeros.
// Ports:
//   aclk, aresetn    : clock, asynchronous active-low reset
//   en               : run enable for the tick counter
//   gain_shift       : left-shift 0..15, sampled on each swap
//   s_axis           : input word stream (slave side)
//   m_frame_tdata    : parallel frame, word i at [i*SAMP_WIDTH +: SAMP_WIDTH]
//   m_frame_tvalid   : one-cycle strobe per output frame
//   underflow_cnt    : ticks without a pending frame (saturating)
//   frame_err_cnt    : framing errors (saturating)
module tx_frame_unpacker #(
    parameter int SAMP_WIDTH = 16,
    parameter int NUM_CHANS  = 13,
    parameter int INTERP     = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              en,
    input  logic [3:0]                        gain_shift,
    tx_frame_unpacker_if.slave                s_axis,
    output logic [2*NUM_CHANS*SAMP_WIDTH-1:0] m_frame_tdata,
    output logic                              m_frame_tvalid,
    output logic [CNT_WIDTH-1:0]              underflow_cnt,
    output logic [CNT_WIDTH-1:0]              frame_err_cnt
);
    localparam int WORDS  = 2 * NUM_CHANS;
    localparam int IDX_W  = $clog2(WORDS);
    localparam int TICK_W = $clog2(INTERP);
    localparam int EXT_W  = SAMP_WIDTH + 15;

    typedef enum logic {COLLECT, RESYNC} state_t;

    state_t                  state, state_nxt;
    logic                    ready_q;
    logic                    pending_full;
    logic [IDX_W-1:0]        idx;
    logic [SAMP_WIDTH-1:0]   pend [WORDS];
    logic [TICK_W-1:0]       tick_cnt;
    logic                    tick;
    logic                    collect_wr;
    logic                    frame_done;
    logic                    frame_err;
    logic                    idx_clr;

    // Overflow when the bits above the result's sign bit disagree with it.
    function automatic logic [SAMP_WIDTH-1:0] sat_shift(
        input logic [SAMP_WIDTH-1:0] w,
        input logic [3:0]            sh
    );
        logic signed [EXT_W-1:0] ext;
        ext = EXT_W'(signed'(w)) <<< sh;
        if (ext[EXT_W-1:SAMP_WIDTH-1] != {(EXT_W-SAMP_WIDTH+1){ext[EXT_W-1]}})
            return ext[EXT_W-1] ? {1'b1, {(SAMP_WIDTH-1){1'b0}}}
                                : {1'b0, {(SAMP_WIDTH-1){1'b1}}};
        return ext[SAMP_WIDTH-1:0];
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= COLLECT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        s_axis.tready = 1'b0;
        collect_wr    = 1'b0;
        frame_done    = 1'b0;
        frame_err     = 1'b0;
        idx_clr       = 1'b0;
        case (state)
            COLLECT: begin
                s_axis.tready = ready_q && !pending_full;
                collect_wr    = s_axis.tvalid && ready_q && !pending_full;
                if (collect_wr) begin
                    if (idx == IDX_W'(WORDS - 1)) begin
                        idx_clr = 1'b1;
                        if (s_axis.tlast) begin
                            frame_done = 1'b1;
                        end else begin
                            frame_err = 1'b1;
                            state_nxt = RESYNC;
                        end
                    end else if (s_axis.tlast) begin
                        frame_err = 1'b1;
                        idx_clr   = 1'b1;
                    end
                end
            end
            RESYNC: begin
                s_axis.tready = ready_q;
                if (s_axis.tvalid && ready_q && s_axis.tlast) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    assign tick = en && (tick_cnt == TICK_W'(INTERP - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_q      <= 1'b0;
            idx          <= '0;
            tick_cnt     <= '0;
            pending_full <= 1'b0;
        end else begin
            ready_q <= 1'b1;

            if (idx_clr)         idx <= '0;
            else if (collect_wr) idx <= idx + 1'b1;

            if (!en || tick) tick_cnt <= '0;
            else             tick_cnt <= tick_cnt + 1'b1;

            // A frame completing on the tick cycle is not yet pending, so the
            // swap cannot clear it; both branches are mutually exclusive.
            if (frame_done)                pending_full <= 1'b1;
            else if (tick && pending_full) pending_full <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (collect_wr) pend[idx] <= s_axis.tdata;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_frame_tdata  <= '0;
            m_frame_tvalid <= 1'b0;
            underflow_cnt  <= '0;
            frame_err_cnt  <= '0;
        end else begin
            m_frame_tvalid <= tick;
            if (tick) begin
                if (pending_full) begin
                    for (int unsigned i = 0; i < WORDS; i++)
                        m_frame_tdata[i*SAMP_WIDTH +: SAMP_WIDTH] <= sat_shift(pend[i], gain_shift);
                end else begin
                    m_frame_tdata <= '0;
                    if (underflow_cnt != '1) underflow_cnt <= underflow_cnt + 1'b1;
                end
            end
            if (frame_err && frame_err_cnt != '1) frame_err_cnt <= frame_err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_tx_frame_unpacker.sv
module tb_tx_frame_unpacker;
    localparam int W  = 16;
    localparam int N  = 13;
    localparam int FW = 2 * N * W;

    logic          aclk;
    logic          aresetn;
    logic          en;
    logic [3:0]    gain_shift;
    logic [FW-1:0] m_frame_tdata;
    logic          m_frame_tvalid;
    logic [15:0]   underflow_cnt;
    logic [15:0]   frame_err_cnt;

    int compared = 0;
    int mismatched = 0;

    tx_frame_unpacker_if #(.SAMP_WIDTH(W)) s_axis ();

    tx_frame_unpacker #(
        .SAMP_WIDTH(W),
        .NUM_CHANS (N),
        .INTERP    (64),
        .CNT_WIDTH (16)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .en            (en),
        .gain_shift    (gain_shift),
        .s_axis        (s_axis),
        .m_frame_tdata (m_frame_tdata),
        .m_frame_tvalid(m_frame_tvalid),
        .underflow_cnt (underflow_cnt),
        .frame_err_cnt (frame_err_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send(input logic [W-1:0] d, input logic last);
        int g;
        s_axis.tdata  = d;
        s_axis.tlast  = last;
        s_axis.tvalid = 1'b1;
        g = 0;
        while (!s_axis.tready && g < 300) begin
            @(negedge aclk);
            g++;
        end
        if (!s_axis.tready) check("send_ready_timeout", 1'b0, 1'b1);
        @(posedge aclk);
        @(negedge aclk);
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < 2 * N; i++) send(16'(base + i + 1), i == 2 * N - 1);
    endtask

    function automatic logic [FW-1:0] ramp(input int base);
        logic [FW-1:0] v;
        v = '0;
        for (int i = 0; i < 2 * N; i++) v[i*W +: W] = 16'(base + i + 1);
        return v;
    endfunction

    task automatic wait_strobe();
        int g;
        g = 0;
        do begin
            @(negedge aclk);
            g++;
        end while (!m_frame_tvalid && g < 300);
        check("strobe_seen", m_frame_tvalid, 1'b1);
    endtask

    logic [FW-1:0] exp_v;

    initial begin
        aresetn = 1'b0;
        en = 1'b0;
        gain_shift = 4'd0;
        s_axis.tdata = '0;
        s_axis.tvalid = 1'b0;
        s_axis.tlast = 1'b0;

        // Reset state
        repeat (3) @(negedge aclk);
        check("rst_tready", s_axis.tready, 1'b0);
        check("rst_tvalid", m_frame_tvalid, 1'b0);
        check("rst_tdata", m_frame_tdata, '0);
        check("rst_uflow", underflow_cnt, '0);
        check("rst_ferr", frame_err_cnt, '0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst_tready", s_axis.tready, 1'b1);

        // Sequential fill 1..26, gain 0
        send_frame(0);
        check("full_tready_low", s_axis.tready, 1'b0);
        en = 1'b1;
        wait_strobe();
        check("seq_frame", m_frame_tdata, ramp(0));
        check("seq_ch0_re", m_frame_tdata[15:0], 16'd1);
        check("seq_ch12_im", m_frame_tdata[FW-1 -: W], 16'd26);
        check("seq_tready_back", s_axis.tready, 1'b1);
        check("seq_uflow", underflow_cnt, '0);
        en = 1'b0;

        // Gain saturation, shift 4
        gain_shift = 4'd4;
        send(16'h0100, 1'b0);
        send(16'h0900, 1'b0);
        send(16'hF800, 1'b0);
        send(16'h8001, 1'b0);
        for (int i = 4; i < 2 * N; i++) send(16'h0000, i == 2 * N - 1);
        en = 1'b1;
        wait_strobe();
        exp_v = '0;
        exp_v[0*W +: W] = 16'h1000;
        exp_v[1*W +: W] = 16'h7FFF;
        exp_v[2*W +: W] = 16'h8000;
        exp_v[3*W +: W] = 16'h8000;
        check("gain_sat", m_frame_tdata, exp_v);
        en = 1'b0;
        gain_shift = 4'd0;

        // Early tlast on word 10, then good frame
        for (int i = 1; i <= 10; i++) send(16'(i), i == 10);
        check("early_last_err", frame_err_cnt, 16'd1);
        send_frame(100);
        en = 1'b1;
        wait_strobe();
        check("after_early_frame", m_frame_tdata, ramp(100));
        en = 1'b0;

        // Missing tlast, strays, then good frame
        for (int i = 0; i < 2 * N; i++) send(16'(500 + i), 1'b0);
        for (int i = 0; i < 5; i++) send(16'(900 + i), i == 4);
        check("missing_last_err", frame_err_cnt, 16'd2);
        send_frame(200);
        en = 1'b1;
        wait_strobe();
        check("after_resync_frame", m_frame_tdata, ramp(200));
        en = 1'b0;
        check("no_uflow_yet", underflow_cnt, '0);

        // Three ticks with no input
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_strobe();
            check("uflow_zero_data", m_frame_tdata, '0);
            check("uflow_tready", s_axis.tready, 1'b1);
        end
        check("uflow_cnt3", underflow_cnt, 16'd3);
        en = 1'b0;

        // Last word accepted on the tick cycle: tick edge is the 64th edge after en rises
        @(negedge aclk);
        en = 1'b1;
        repeat (38) @(negedge aclk);
        send_frame(400);
        check("coinc_strobe", m_frame_tvalid, 1'b1);
        check("coinc_zero", m_frame_tdata, '0);
        check("coinc_uflow", underflow_cnt, 16'd4);
        wait_strobe();
        check("coinc_frame_next", m_frame_tdata, ramp(400));
        check("coinc_uflow_hold", underflow_cnt, 16'd4);
        en = 1'b0;

        // Reset mid-frame at word 7
        for (int i = 1; i <= 7; i++) send(16'(700 + i), 1'b0);
        aresetn = 1'b0;
        @(negedge aclk);
        check("midrst_tready", s_axis.tready, 1'b0);
        check("midrst_tdata", m_frame_tdata, '0);
        aresetn = 1'b1;
        @(negedge aclk);
        send_frame(300);
        en = 1'b1;
        wait_strobe();
        check("midrst_frame", m_frame_tdata, ramp(300));
        check("midrst_uflow", underflow_cnt, '0);
        check("midrst_ferr", frame_err_cnt, '0);
        en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
